// File: rtl/risc_defs.sv
`default_nettype none
// ============================================================================
// Package  : risc_defs
// Brief    : Shared datapath width, opcodes, load funct3 codes and writeback
//            source encodings for the integer pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package risc_defs;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_OPI  = 7'b0010011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [2:0] LB   = 3'b000;
    localparam logic [2:0] LH   = 3'b001;
    localparam logic [2:0] LW   = 3'b010;
    localparam logic [2:0] LD   = 3'b011;
    localparam logic [2:0] LBU  = 3'b100;
    localparam logic [2:0] LHU  = 3'b101;
    localparam logic [2:0] LWU  = 3'b110;
    localparam logic [2:0] LRSV = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_RSV = 2'b11;

endpackage : risc_defs
`default_nettype wire

// File: rtl/wb_load_extract.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_extract
// Brief    : Combinational load-data extraction: selects the addressed
//            byte/half/word from a doubleword and sign- or zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_extract
    import risc_defs::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_val
);

    logic [31:0] w_word;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Sub-lane offset bits below the access size are ignored, not trapped.
    assign w_word = rdata[{off[2], 5'b0} +: 32];
    assign w_half = rdata[{off[2:1], 4'b0} +: 16];
    assign w_byte = rdata[{off, 3'b0} +: 8];

    always_comb begin
        ld_val = '0;
        case (funct3)
            LD:   ld_val = rdata;
            LW:   ld_val = {{(XLEN-32){w_word[31]}}, w_word};
            LWU:  ld_val = {{(XLEN-32){1'b0}}, w_word};
            LH:   ld_val = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:  ld_val = {{(XLEN-16){1'b0}}, w_half};
            LB:   ld_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:  ld_val = {{(XLEN-8){1'b0}}, w_byte};
            LRSV: ld_val = '0;
        endcase
    end

endmodule : wb_load_extract
`default_nettype wire

// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_stage
// Brief    : Writeback stage and 32 x XLEN integer register file with two
//            bypassed read ports and a registered forwarding copy.
// Config   : WB_RETIRE_CNT_EN adds instret / retire_valid outputs.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_stage #(
    parameter int          XLEN   = risc_defs::XLEN,
    parameter int          NREGS  = 32,
    parameter logic [31:0] RST_PC = 32'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_in,
    input  logic [31:0]     pc_in,
    input  logic [XLEN-1:0] ALUres,
    input  logic [XLEN-1:0] rdata,
    input  logic            RegWrite,
    input  logic [1:0]      MemtoReg,
    input  logic            LoadData,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            fwd_we,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     instret,
    output logic            retire_valid,
`endif
    output logic [31:0]     retire_pc
);

    import risc_defs::*;

    logic [XLEN-1:0] r_regs [NREGS];
    logic            r_fwd_we;
    logic [4:0]      r_fwd_rd;
    logic [XLEN-1:0] r_fwd_data;
    logic [31:0]     r_retire_pc;

    logic [4:0]      w_rd;
    logic            w_we;
    logic            w_valid;
    logic [31:0]     w_pc4;
    logic [XLEN-1:0] w_ld_val;
    logic [XLEN-1:0] w_wb_data;
    logic            w_unused;

    // Load selection is fully decoded from MemtoReg; LoadData is redundant here.
    assign w_unused = LoadData;

    assign w_rd    = inst_in[11:7];
    assign w_valid = (inst_in != 32'd0);
    assign w_we    = RegWrite && (w_rd != 5'd0) && w_valid;
    assign w_pc4   = pc_in + 32'd4;

    wb_load_extract u_load_extract (
        .funct3 (inst_in[14:12]),
        .off    (ALUres[2:0]),
        .rdata  (rdata),
        .ld_val (w_ld_val)
    );

    always_comb begin
        w_wb_data = '0;
        case (MemtoReg)
            WB_ALU:  w_wb_data = ALUres;
            WB_MEM:  w_wb_data = w_ld_val;
            WB_PC4:  w_wb_data = {{(XLEN-32){1'b0}}, w_pc4};
            default: w_wb_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_fwd_we    <= 1'b0;
            r_fwd_rd    <= 5'd0;
            r_fwd_data  <= '0;
            r_retire_pc <= RST_PC;
        end else begin
            if (w_we) begin
                r_regs[w_rd] <= w_wb_data;
                r_fwd_rd     <= w_rd;
                r_fwd_data   <= w_wb_data;
            end
            r_fwd_we <= w_we;
            if (w_valid) begin
                r_retire_pc <= pc_in;
            end
        end
    end

    // The in-flight write is visible to ID in the same cycle it commits.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            if (w_we && (rs1_addr == w_rd)) begin
                rs1_data = w_wb_data;
            end else begin
                rs1_data = r_regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            if (w_we && (rs2_addr == w_rd)) begin
                rs2_data = w_wb_data;
            end else begin
                rs2_data = r_regs[rs2_addr];
            end
        end
    end

    assign fwd_we    = r_fwd_we;
    assign fwd_rd    = r_fwd_rd;
    assign fwd_data  = r_fwd_data;
    assign retire_pc = r_retire_pc;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_instret;
    logic        r_retire_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret      <= 64'd0;
            r_retire_valid <= 1'b0;
        end else begin
            r_retire_valid <= w_valid;
            if (w_valid) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign instret      = r_instret;
    assign retire_valid = r_retire_valid;
`endif

endmodule : wb_regfile_stage
`default_nettype wire
